// File: rtl/jk_cmd_pkg.sv
// Shared types and command encodings for the J/K command encoder.
// The {j,k} bit order follows the downstream flip-flop's case encoding.
package jk_cmd_pkg;

  typedef enum logic [1:0] {IDLE, PAIR, EMIT, LOCK} state_t;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_CLR  = 2'b01;
  localparam logic [1:0] CMD_SET  = 2'b10;
  localparam logic [1:0] CMD_TOG  = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/jk_cmd_encoder_btn_debounce.sv
// Two-flop synchroniser plus counter debounce for one raw pushbutton.
// press is high in the single cycle where the debounced level loads 1.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic db,
  output logic press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic          s1;
  logic          s2;
  logic [DW-1:0] cnt;
  logic          load;

  assign load  = (s2 != db) && (cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign press = load && s2;

  // The level only follows s once it has differed for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (load) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/jk_cmd_encoder.sv
// Turns debounced SET/CLR presses into one-cycle J/K pulses, merging
// near-simultaneous presses into a toggle and issuing one command per gesture.
module jk_cmd_encoder
  import jk_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int PAIR_WINDOW     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_set,
  input  logic btn_clr,
  output logic j,
  output logic k,
  output logic busy
);

  localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, PAIR_WINDOW)) + 1;

  logic             db_set, db_clr;
  logic             press_set, press_clr;
  state_t           state, state_next;
  logic [1:0]       pending, pending_next;
  logic [1:0]       cmd, cmd_next;
  logic [CNT_W-1:0] wcnt, wcnt_next;
  logic             other_press;
  logic             j_next, k_next, busy_next;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
    .clk(clk), .reset(reset), .btn(btn_set), .db(db_set), .press(press_set)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk(clk), .reset(reset), .btn(btn_clr), .db(db_clr), .press(press_clr)
  );

  assign other_press = (pending == CMD_SET) ? press_clr : press_set;

  always_comb begin
    state_next   = state;
    pending_next = pending;
    cmd_next     = cmd;
    wcnt_next    = wcnt;
    j_next       = 1'b0;
    k_next       = 1'b0;
    unique case (state)
      IDLE: begin
        if (press_set && press_clr) begin
          state_next = EMIT;
          cmd_next   = CMD_TOG;
        end else if (press_set || press_clr) begin
          state_next   = PAIR;
          pending_next = press_set ? CMD_SET : CMD_CLR;
          wcnt_next    = '0;
        end
      end
      PAIR: begin
        // A second press of the same button is not a merge; only the other one counts.
        if (other_press) begin
          state_next = EMIT;
          cmd_next   = CMD_TOG;
        end else if (wcnt == CNT_W'(PAIR_WINDOW - 1)) begin
          state_next = EMIT;
          cmd_next   = pending;
        end else begin
          wcnt_next = wcnt + 1'b1;
        end
      end
      EMIT: begin
        {j_next, k_next} = cmd;
        state_next       = LOCK;
      end
      LOCK: begin
        if (!db_set && !db_clr) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= CMD_NONE;
      cmd     <= CMD_NONE;
      wcnt    <= '0;
      j       <= 1'b0;
      k       <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      cmd     <= cmd_next;
      wcnt    <= wcnt_next;
      j       <= j_next;
      k       <= k_next;
      busy    <= busy_next;
    end
  end

endmodule

// File: doc/jk_cmd_encoder.md
Name: jk_cmd_encoder

Overview:
- Converts two raw board pushbuttons (SET, CLR) into clean, single-cycle J/K command pulses.
- Its j/k outputs drive the j/k inputs of the JK flip-flop stage directly downstream.
- Each button is synchronised and debounced. Near-simultaneous presses of both buttons merge into a toggle (J=K=1).
- Exactly one command is issued per press gesture.

Parameters:
- DEBOUNCE_CYCLES, 8, consecutive stable synchronised samples required before a debounced level changes (>=2).
- PAIR_WINDOW, 4, cycles after a first press during which the second button's press merges into a toggle (>=1).
- CNT_W, $clog2(max(DEBOUNCE_CYCLES,PAIR_WINDOW))+1, counter width (derived, not overridden).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- btn_set  input  1  raw SET button, asynchronous, may bounce
- btn_clr  input  1  raw CLR button, asynchronous, may bounce
- j  output  1  registered J command pulse, one cycle wide
- k  output  1  registered K command pulse, one cycle wide
- busy  output  1  registered, high whenever FSM is not in IDLE

Behaviour:
- Reset:
  - Synchronous, active-high, sampled on the rising edge of clk.
  - Clears sync flops, debounced levels (0), all counters, pending command, and FSM state (IDLE).
  - j=0, k=0, busy=0 from the first edge with reset high.
- Reset mid-operation: any pending or merging command is discarded and no pulse is emitted. A button still held after reset releases is re-debounced from level 0, so it produces a fresh press event.
- Synchroniser: 2-flop chain per button; output s.
- Debounce, per button, with registered level db and counter cnt:
  - If s==db: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: db<=s, cnt<=0.
  - Else: cnt<=cnt+1.
  - Press event is combinational: high in the cycle db loads 1. A release event (db loading 0) produces no command.
- FSM states: IDLE, PAIR, EMIT, LOCK.
  - IDLE:
    - Both presses in the same cycle -> EMIT with cmd=TOG.
    - SET press only -> PAIR with pending=SET, wcnt=0.
    - CLR press only -> PAIR with pending=CLR, wcnt=0.
  - PAIR:
    - Press of the other button -> EMIT with cmd=TOG.
    - Otherwise, wcnt==PAIR_WINDOW-1 -> EMIT with cmd=pending.
    - Otherwise wcnt++.
    - A repeat press of the same button is ignored.
  - EMIT: j/k registered from cmd for exactly one cycle (SET=10, CLR=01, TOG=11); then -> LOCK.
  - LOCK: stay until both db levels are 0, then -> IDLE. Presses in LOCK are ignored (one command per gesture).
- Output timing: j=k=0 in every cycle except the single cycle following the EMIT cycle. j=k=0 never produces a pulse (no-op is not encoded).
- Latency, single isolated press, raw input stable high from edge N:
  - db=1 at edge N+2+DEBOUNCE_CYCLES.
  - Pulse visible after edge N+2+DEBOUNCE_CYCLES+PAIR_WINDOW+1.
  - With defaults: high during the cycle after edge N+15.
- Bounce: any glitch shorter than DEBOUNCE_CYCLES synchronised cycles leaves db unchanged and issues no command.
- busy: high from the cycle after the IDLE exit until LOCK returns to IDLE.

Decomposition:
- Shared package jk_cmd_pkg:
  - State enum {IDLE, PAIR, EMIT, LOCK}.
  - Command constants CMD_NONE=2'b00, CMD_CLR=2'b01, CMD_SET=2'b10, CMD_TOG=2'b11.
  - The {j,k} bit order matches the flip-flop's case encoding.
- One sub-module, btn_debounce, instantiated twice:
  - Contains the 2-flop synchroniser and the debounce counter.
  - Outputs db level and a one-cycle press pulse.
  - Parameter DEBOUNCE_CYCLES; same clk/reset.

Test Plan:
- Reset check: assert reset 3 cycles with both buttons toggling -> j=k=busy=0 throughout; no pulse for 20 cycles after release with buttons low.
- SET press: btn_set rises at edge N and is held 30 cycles -> j=1,k=0 for exactly one cycle after edge N+15; no further pulse while held; busy falls 1 cycle after db_set returns to 0.
- CLR press with bounce: btn_clr toggles 1,0,1,0 at 1-cycle spacing, then holds high from edge N -> j=0,k=1 exactly once after edge N+15; bounce alone (pulses <8 cycles) -> no command.
- Toggle merge: btn_set high at edge N, btn_clr high at N+2, both held -> single j=1,k=1 pulse one cycle after the CLR press event; no separate SET pulse. With btn_clr at N+6 (outside the window) -> SET pulse only; CLR ignored in LOCK.
- Reset mid-operation: btn_set held, reset asserted during PAIR -> no pulse; after reset releases with the button still held -> SET pulse 2+8+4+1 cycles later.
- Downstream integration: drive JK_FLIP_FLOP with j/k; sequence SET, CLR, TOG, TOG -> q=1,0,1,0 and qn always ~q.
